// File: rtl/treat_store_buffer.sv
// MEM-stage store buffer: formats stores into byte lanes, rejects misaligned ones,
// queues accepted stores in order toward data memory and flags load/store word hits.
module treat_store_buffer #(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 32,
  parameter int DEPTH        = 4,
  parameter int OPCODE_WIDTH = 6,
  // Encodings must match STORE / STORE_BYTE / STORE_HALF of the shared opcode header.
  parameter logic [OPCODE_WIDTH-1:0] STORE      = OPCODE_WIDTH'(20),
  parameter logic [OPCODE_WIDTH-1:0] STORE_BYTE = OPCODE_WIDTH'(21),
  parameter logic [OPCODE_WIDTH-1:0] STORE_HALF = OPCODE_WIDTH'(22)
) (
  input  logic                    tsb_i_clk,
  input  logic                    tsb_i_rst,
  input  logic                    tsb_i_valid,
  input  logic [OPCODE_WIDTH-1:0] tsb_i_opcode,
  input  logic [AWIDTH-1:0]       tsb_i_addr,
  input  logic [DWIDTH-1:0]       tsb_i_data,
  output logic                    tsb_o_ready,
  output logic                    tsb_o_misaligned,
  output logic                    tsb_o_mem_valid,
  output logic [AWIDTH-1:0]       tsb_o_mem_addr,
  output logic [DWIDTH-1:0]       tsb_o_mem_data,
  output logic [3:0]              tsb_o_mem_be,
  input  logic                    tsb_i_mem_ready,
  input  logic [AWIDTH-1:0]       tsb_i_chk_addr,
  output logic                    tsb_o_chk_hit,
  output logic                    tsb_o_empty,
  output logic [$clog2(DEPTH):0]  tsb_o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AWIDTH-1:0] r_addr [DEPTH];
  logic [DWIDTH-1:0] r_data [DEPTH];
  logic [3:0]        r_be   [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_mis;

  logic              w_is_b;
  logic              w_is_h;
  logic              w_is_w;
  logic              w_store;
  logic              w_misal;
  logic              w_enq;
  logic              w_deq;
  logic              w_empty;
  logic [AWIDTH-1:0] w_fmt_addr;
  logic [DWIDTH-1:0] w_fmt_data;
  logic [3:0]        w_fmt_be;
  logic              w_hit;
  logic              w_unused_chk;

  assign w_is_b  = tsb_i_opcode == STORE_BYTE;
  assign w_is_h  = tsb_i_opcode == STORE_HALF;
  assign w_is_w  = tsb_i_opcode == STORE;
  assign w_store = tsb_i_valid && (w_is_b || w_is_h || w_is_w);
  assign w_misal = (w_is_h && tsb_i_addr[0]) ||
                   (w_is_w && (tsb_i_addr[1:0] != 2'b00));

  assign w_empty = r_count == '0;
  assign w_enq   = w_store && !w_misal && tsb_o_ready;
  assign w_deq   = !w_empty && tsb_i_mem_ready;

  assign w_fmt_addr = {tsb_i_addr[AWIDTH-1:2], 2'b00};

  // Replicate data into byte lanes and build byte enables from the offset
  always_comb begin
    w_fmt_data = tsb_i_data;
    w_fmt_be   = 4'b1111;
    unique case (1'b1)
      w_is_b: begin
        w_fmt_data = {4{tsb_i_data[7:0]}};
        w_fmt_be   = 4'b0001 << tsb_i_addr[1:0];
      end
      w_is_h: begin
        w_fmt_data = {2{tsb_i_data[15:0]}};
        w_fmt_be   = tsb_i_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_fmt_data = tsb_i_data;
        w_fmt_be   = 4'b1111;
      end
    endcase
  end

  // FIFO storage, pointers, occupancy and the misaligned pulse
  always_ff @(posedge tsb_i_clk or negedge tsb_i_rst) begin
    if (!tsb_i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_be[i]   <= '0;
      end
      r_vld   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_mis   <= 1'b0;
    end else begin
      r_mis <= w_store && w_misal;
      // enq and deq never touch the same slot: that needs empty or full
      if (w_deq) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + PW'(1);
      end
      if (w_enq) begin
        r_addr[r_wptr] <= w_fmt_addr;
        r_data[r_wptr] <= w_fmt_data;
        r_be[r_wptr]   <= w_fmt_be;
        r_vld[r_wptr]  <= 1'b1;
        r_wptr         <= r_wptr + PW'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Word-address match of a load against every pending entry
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] &&
          (r_addr[i][AWIDTH-1:2] == tsb_i_chk_addr[AWIDTH-1:2]))
        w_hit = 1'b1;
    end
  end

  assign w_unused_chk = &{1'b0, tsb_i_chk_addr[1:0]};

  assign tsb_o_ready      = r_count != FULL;
  assign tsb_o_empty      = w_empty;
  assign tsb_o_count      = r_count;
  assign tsb_o_mem_valid  = !w_empty;
  assign tsb_o_mem_addr   = r_addr[r_rptr];
  assign tsb_o_mem_data   = r_data[r_rptr];
  assign tsb_o_mem_be     = r_be[r_rptr];
  assign tsb_o_misaligned = r_mis;
  assign tsb_o_chk_hit    = w_hit;

endmodule

// File: tb/tb_treat_store_buffer.sv
// Directed bench for treat_store_buffer: formatting, misalignment,
// full/stall behaviour, hit check and reset flush.
module tb_treat_store_buffer;

  localparam int OW = 6;
  localparam logic [OW-1:0] OP_SW  = OW'(20);
  localparam logic [OW-1:0] OP_SB  = OW'(21);
  localparam logic [OW-1:0] OP_SH  = OW'(22);
  localparam logic [OW-1:0] OP_ADD = OW'(3);

  logic          clk;
  logic          rst_n;
  logic          valid;
  logic [OW-1:0] opcode;
  logic [31:0]   addr;
  logic [31:0]   data;
  logic          ready;
  logic          mis;
  logic          mvalid;
  logic [31:0]   maddr;
  logic [31:0]   mdata;
  logic [3:0]    mbe;
  logic          mready;
  logic [31:0]   caddr;
  logic          hit;
  logic          empty;
  logic [2:0]    count;

  int n_chk = 0;
  int n_err = 0;

  treat_store_buffer #(
    .DWIDTH(32), .AWIDTH(32), .DEPTH(4), .OPCODE_WIDTH(OW),
    .STORE(OP_SW), .STORE_BYTE(OP_SB), .STORE_HALF(OP_SH)
  ) dut (
    .tsb_i_clk(clk),
    .tsb_i_rst(rst_n),
    .tsb_i_valid(valid),
    .tsb_i_opcode(opcode),
    .tsb_i_addr(addr),
    .tsb_i_data(data),
    .tsb_o_ready(ready),
    .tsb_o_misaligned(mis),
    .tsb_o_mem_valid(mvalid),
    .tsb_o_mem_addr(maddr),
    .tsb_o_mem_data(mdata),
    .tsb_o_mem_be(mbe),
    .tsb_i_mem_ready(mready),
    .tsb_i_chk_addr(caddr),
    .tsb_o_chk_hit(hit),
    .tsb_o_empty(empty),
    .tsb_o_count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [OW-1:0] op, input logic [31:0] a,
                     input logic [31:0] d);
    valid  = 1'b1;
    opcode = op;
    addr   = a;
    data   = d;
  endtask

  initial begin
    rst_n  = 1'b0;
    valid  = 1'b0;
    opcode = '0;
    addr   = '0;
    data   = '0;
    mready = 1'b0;
    caddr  = '0;
    #3;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_mvalid", 32'(mvalid), 32'd0);
    chk("rst_mis", 32'(mis), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_maddr", maddr, 32'd0);
    chk("rst_mdata", mdata, 32'd0);
    chk("rst_mbe", 32'(mbe), 32'd0);
    #4 rst_n = 1'b1;
    tick();

    // SB at offset 3 drains immediately
    mready = 1'b1;
    req(OP_SB, 32'h1003, 32'h0000_00A5);
    tick();
    valid = 1'b0;
    chk("sb_mvalid", 32'(mvalid), 32'd1);
    chk("sb_addr", maddr, 32'h1000);
    chk("sb_data", mdata, 32'hA5A5_A5A5);
    chk("sb_be", 32'(mbe), 32'h8);
    chk("sb_count", 32'(count), 32'd1);
    tick();
    chk("sb_empty", 32'(empty), 32'd1);
    chk("sb_mvalid0", 32'(mvalid), 32'd0);

    // SH upper half, then misaligned SH
    mready = 1'b0;
    req(OP_SH, 32'h2002, 32'h0000_BEEF);
    tick();
    valid = 1'b0;
    chk("sh_data", mdata, 32'hBEEF_BEEF);
    chk("sh_be", 32'(mbe), 32'hC);
    chk("sh_addr", maddr, 32'h2000);
    chk("sh_mis", 32'(mis), 32'd0);
    mready = 1'b1;
    tick();
    chk("sh_empty", 32'(empty), 32'd1);
    req(OP_SH, 32'h2001, 32'h0000_1234);
    tick();
    valid = 1'b0;
    chk("shm_mis", 32'(mis), 32'd1);
    chk("shm_count", 32'(count), 32'd0);
    tick();
    chk("shm_mis_end", 32'(mis), 32'd0);

    // SW passthrough, misaligned SW, non-store ignored
    mready = 1'b0;
    req(OP_SW, 32'h3004, 32'h1234_5678);
    tick();
    valid = 1'b0;
    chk("sw_data", mdata, 32'h1234_5678);
    chk("sw_be", 32'(mbe), 32'hF);
    chk("sw_addr", maddr, 32'h3004);
    mready = 1'b1;
    tick();
    chk("sw_empty", 32'(empty), 32'd1);
    req(OP_SW, 32'h3006, 32'hDEAD_BEEF);
    tick();
    valid = 1'b0;
    chk("swm_mis", 32'(mis), 32'd1);
    chk("swm_count", 32'(count), 32'd0);
    tick();
    chk("swm_mis_end", 32'(mis), 32'd0);
    req(OP_ADD, 32'h3001, 32'hCAFE_F00D);
    tick();
    valid = 1'b0;
    chk("nop_count", 32'(count), 32'd0);
    chk("nop_mis", 32'(mis), 32'd0);
    chk("nop_mvalid", 32'(mvalid), 32'd0);

    // Fill to full while stalled; 5th store dropped
    mready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req(OP_SW, 32'h5000 + 32'(4 * i), 32'hD000_0000 + 32'(i));
      if (i == 4) chk("full_ready", 32'(ready), 32'd0);
      tick();
    end
    valid = 1'b0;
    chk("full_count", 32'(count), 32'd4);
    chk("stall_addr0", maddr, 32'h5000);
    tick();
    chk("stall_addr1", maddr, 32'h5000);
    chk("stall_data1", mdata, 32'hD000_0000);
    chk("stall_be1", 32'(mbe), 32'hF);
    // Dequeue while full does not reopen ready this cycle
    mready = 1'b1;
    req(OP_SW, 32'h6000, 32'h6666_6666);
    tick();
    valid = 1'b0;
    chk("full_deq_count", 32'(count), 32'd3);
    for (int i = 1; i < 4; i++) begin
      chk("drain_addr", maddr, 32'h5000 + 32'(4 * i));
      chk("drain_data", mdata, 32'hD000_0000 + 32'(i));
      tick();
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_ready", 32'(ready), 32'd1);

    // Simultaneous enqueue and dequeue keeps count
    mready = 1'b0;
    req(OP_SW, 32'h7000, 32'h7000_0000);
    tick();
    mready = 1'b1;
    req(OP_SW, 32'h7004, 32'h7000_0004);
    tick();
    valid = 1'b0;
    chk("sim_count", 32'(count), 32'd1);
    chk("sim_addr", maddr, 32'h7004);
    tick();
    chk("sim_empty", 32'(empty), 32'd1);

    // Hit check
    mready = 1'b0;
    req(OP_SW, 32'h4000, 32'h1);
    tick();
    req(OP_SW, 32'h4010, 32'h2);
    tick();
    valid = 1'b0;
    caddr = 32'h4002;
    #1 chk("hit_4002", 32'(hit), 32'd1);
    caddr = 32'h4008;
    #1 chk("hit_4008", 32'(hit), 32'd0);
    caddr = 32'h4013;
    #1 chk("hit_4013", 32'(hit), 32'd1);
    mready = 1'b1;
    tick();
    tick();
    caddr = 32'h4002;
    #1 chk("hit_after", 32'(hit), 32'd0);
    chk("hit_empty", 32'(empty), 32'd1);

    // Reset mid-transfer flushes everything
    mready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req(OP_SW, 32'h8000 + 32'(4 * i), 32'h8000_0000 + 32'(i));
      tick();
    end
    valid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd3);
    mready = 1'b1;
    tick();
    chk("mid_count", 32'(count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mvalid", 32'(mvalid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_maddr", maddr, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_mvalid", 32'(mvalid), 32'd0);
    chk("post_count", 32'(count), 32'd0);
    tick();
    chk("post_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/treat_store_buffer.md
# treat_store_buffer

Store-side counterpart of the load-data extension path in the MEM stage. Takes store requests from the pipeline, formats the data into byte lanes with byte enables, and rejects misaligned accesses. Accepted stores go into a small FIFO that drains to data memory over a valid/ready handshake. A combinational word-address check lets the hazard logic stall loads that hit a pending store.

## Interface
- DWIDTH, 32, data width; only 32 is supported, giving 4 byte lanes
- AWIDTH, 32, byte address width
- DEPTH, 4, FIFO entries; must be a power of two and at least 2
- Opcodes use `OPCODE_WIDTH`, `STORE`, `STORE_BYTE` and `STORE_HALF` from header.vh.

Ports:
- tsb_i_clk  in  1  clock, rising edge
- tsb_i_rst  in  1  asynchronous, active-low reset
- tsb_i_valid  in  1  store request present this cycle
- tsb_i_opcode  in  OPCODE_WIDTH  request opcode
- tsb_i_addr  in  AWIDTH  byte address
- tsb_i_data  in  DWIDTH  register data to store, right-justified
- tsb_o_ready  out  1  FIFO not full
- tsb_o_misaligned  out  1  registered one-cycle pulse for a misaligned store
- tsb_o_mem_valid  out  1  head entry valid toward memory
- tsb_o_mem_addr  out  AWIDTH  word-aligned address; bits [1:0] are always 0
- tsb_o_mem_data  out  DWIDTH  lane-replicated store data
- tsb_o_mem_be  out  4  byte enables; bit i enables byte lane i
- tsb_i_mem_ready  in  1  memory accepts the head entry
- tsb_i_chk_addr  in  AWIDTH  load address to check
- tsb_o_chk_hit  out  1  a pending entry has the same word address
- tsb_o_empty  out  1  FIFO empty
- tsb_o_count  out  $clog2(DEPTH)+1  number of entries held

## Operation
Request classes:
- Store opcode: tsb_i_valid=1 and opcode is one of STORE, STORE_BYTE, STORE_HALF.
- Any other opcode while valid: ignored. No enqueue and no misaligned pulse.

Misalignment rules:
- STORE_HALF is misaligned when addr[0]=1.
- STORE is misaligned when addr[1:0]≠0.
- STORE_BYTE is never misaligned.

Enqueue:
- Occurs when the request is a store, aligned, and tsb_o_ready=1.
- A misaligned store is never enqueued. It sets tsb_o_misaligned=1 for the next cycle only, independent of ready.

Formatting at enqueue (addr[1:0] = byte offset):
- STORE_BYTE: data = {4{data[7:0]}}, be = 4'b0001 << addr[1:0].
- STORE_HALF: data = {2{data[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
- STORE: data passed through, be = 4'b1111.
- Stored address = {addr[AWIDTH-1:2], 2'b00}.

Dequeue:
- Occurs when tsb_o_mem_valid && tsb_i_mem_ready.
- The mem_* outputs are driven directly from registered head storage.
- tsb_o_mem_valid = !tsb_o_empty.

Head hold rule:
- While tsb_o_mem_valid=1 and tsb_i_mem_ready=0, the head's address, data and be stay stable.
- Entries leave strictly in program order.

FIFO control:
- Read/write pointers wrap modulo DEPTH; tsb_o_count tracks occupancy.
- tsb_o_ready = (count < DEPTH).
- When full, ready is deasserted even if a dequeue happens in the same cycle; no same-cycle bypass of full.
- Simultaneous enqueue and dequeue with 0 < count < DEPTH leaves count unchanged.

Check port:
- tsb_o_chk_hit = OR over all valid entries of (entry word address == tsb_i_chk_addr[AWIDTH-1:2]).
- Purely combinational.
- Does not consider the request being enqueued in the same cycle.

## Timing
Reset (tsb_i_rst=0, asynchronous):
- Pointers and count go to 0, tsb_o_empty=1, tsb_o_ready=1.
- tsb_o_mem_valid=0, tsb_o_misaligned=0, tsb_o_chk_hit=0.
- tsb_o_mem_addr, tsb_o_mem_data and tsb_o_mem_be are 0.
- A reset during operation discards all pending entries; nothing is drained afterwards.

Latency:
- A store accepted at rising edge N is visible on the mem_* outputs from edge N into cycle N+1, when the FIFO was empty.
- An entry is removed at the edge where valid && ready; the next entry appears in the following cycle.
- Full throughput is one store per cycle in and one per cycle out.
- tsb_o_misaligned asserts the cycle after the offending request and lasts exactly one cycle per offending request.
- tsb_o_count, tsb_o_empty and tsb_o_ready are registered-state derived and change only at clock edges.

## Test plan
- SB to 0x1003 with data 0x000000A5 and mem_ready=1 -> next cycle mem_valid=1, mem_addr=0x1000, mem_data=0xA5A5A5A5, be=4'b1000; the entry drains that cycle, after which empty=1.
- SH to 0x2002 with data 0x0000BEEF -> data=0xBEEFBEEF, be=4'b1100. SH to 0x2001 -> not enqueued, misaligned pulses for 1 cycle, count stays 0.
- SW to 0x3004 with data 0x12345678 -> be=4'b1111, data passed through. SW to 0x3006 -> misaligned pulse, no enqueue. A valid request with a non-store opcode -> no effect.
- mem_ready=0 while issuing 5 SW to successive words -> first 4 accepted, ready=0, count=4, 5th dropped. Then mem_ready=1 -> entries drain in order over 4 cycles, and their mem outputs stay stable while stalled.
- Queue SW to 0x4000 and 0x4010, hold mem_ready=0 -> chk_addr=0x4002 gives hit=1, 0x4008 gives hit=0. After both drain, 0x4002 gives hit=0.
- Fill 3 entries, then assert reset mid-transfer -> immediately mem_valid=0, count=0, ready=1. After reset release, no stale entries appear.
